// File: rtl/alu_iter_pkg.sv
// Shared opcode and FSM state definitions for the iterative ALU and the control unit.
package alu_iter_pkg;

    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_MULTU = 3'b101,
        ALU_DIVU  = 3'b110,
        ALU_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Combinational single-cycle datapath: logic ops, add/sub, signed SLT and signed overflow.
module alu_iter_core
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    op_e              op_t;
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             ovf_raw;

    assign op_t = op_e'(op);
    assign sub  = (op_t == ALU_SUB) || (op_t == ALU_SLT);
    assign bx   = sub ? ~b : b;
    assign sum  = a + bx + {{(WIDTH-1){1'b0}}, sub};
    assign ovf_raw = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op_t)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_ADD: begin res = sum; ovf = ovf_raw; end
            ALU_SUB: begin res = sum; ovf = ovf_raw; end
            // signed less-than: the difference sign is wrong exactly when it overflowed
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshake; MULTU/DIVU iterate one bit per clock and share acc.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    state_e           state, state_nx;
    op_e              op_t;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic             accept, last;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_q;

    assign op_t   = op_e'(op);
    assign accept = in_valid && in_ready;
    assign last   = (count == CNT_W'(WIDTH - 1));

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .a   (dataA),
        .b   (dataB),
        .res (core_res),
        .ovf (core_ovf)
    );

    // MUL: acc holds the high half, mplier shifts out multiplier bits and in product bits.
    // DIV: acc holds the partial remainder, mplier shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], mplier[WIDTH-1:1]};
        div_trial = {acc, mplier[WIDTH-1]} - {1'b0, mcand};
        if (div_trial[WIDTH]) begin
            div_rem = {acc[WIDTH-2:0], mplier[WIDTH-1]};
            div_q   = {mplier[WIDTH-2:0], 1'b0};
        end else begin
            div_rem = div_trial[WIDTH-1:0];
            div_q   = {mplier[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (op_t == ALU_MULTU)                       state_nx = MUL;
                else if (op_t == ALU_DIVU && dataB != '0)    state_nx = DIV;
                else                                         state_nx = DONE;
            end
            MUL:     if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == MUL) || (state == DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    count <= '0;
                    case (op_t)
                        ALU_MULTU: begin
                            acc    <= '0;
                            mcand  <= dataA;
                            mplier <= dataB;
                        end
                        ALU_DIVU: begin
                            if (dataB != '0) begin
                                acc    <= '0;
                                mcand  <= dataB;
                                mplier <= dataA;
                            end else begin
                                result    <= '1;
                                result_hi <= dataA;
                                zero      <= 1'b0;
                                ovf       <= 1'b0;
                            end
                        end
                        default: begin
                            result    <= core_res;
                            result_hi <= '0;
                            zero      <= (core_res == '0);
                            ovf       <= core_ovf;
                        end
                    endcase
                end
                MUL: begin
                    acc    <= mul_hi;
                    mplier <= mul_lo;
                    if (last) begin
                        result    <= mul_lo;
                        result_hi <= mul_hi;
                        zero      <= (mul_lo == '0);
                        ovf       <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DIV: begin
                    acc    <= div_rem;
                    mplier <= div_q;
                    if (last) begin
                        result    <= div_q;
                        result_hi <= div_rem;
                        zero      <= (div_q == '0);
                        ovf       <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=32 with hand-computed expectations.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] dataA, dataB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, result_hi;
    logic        zero, ovf, busy;

    int checks   = 0;
    int failures = 0;
    int lat, bcnt;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; lat counts edges from accept.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc);
        @(negedge clk);
        op = o; dataA = a; dataB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1; bc = 0;
        while (!out_valid && l < 100) begin
            bc += int'(busy);
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; dataA = '0; dataB = '0;
        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_result_hi", 64'(result_hi), 64'd0);
        chk("rst_zero",      64'(zero),      64'd1);
        chk("rst_ovf_busy",  {ovf, busy},    64'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(3'b010, 32'h7FFFFFFF, 32'h1, lat, bcnt);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_res", 64'(result), 64'h80000000);
        chk("add_ovf_zero", {ovf, zero}, 64'b10);
        release_out("add");

        do_op(3'b011, 32'd5, 32'd5, lat, bcnt);
        chk("sub_res", 64'(result), 64'd0);
        chk("sub_zero_ovf", {zero, ovf}, 64'b10);
        release_out("sub");

        do_op(3'b100, 32'hFFFFFFFF, 32'd1, lat, bcnt);
        chk("slt_m1_1", 64'(result), 64'd1);
        release_out("slt1");
        do_op(3'b100, 32'h80000000, 32'd1, lat, bcnt);
        chk("slt_min_1", 64'(result), 64'd1);
        chk("slt_ovf", 64'(ovf), 64'd0);
        release_out("slt2");
        do_op(3'b100, 32'd1, 32'hFFFFFFFF, lat, bcnt);
        chk("slt_1_m1", 64'(result), 64'd0);
        release_out("slt3");

        do_op(3'b000, 32'hF0F01234, 32'h0FF0FF00, lat, bcnt);
        chk("and_res", 64'(result), 64'h00F01200);
        release_out("and");
        do_op(3'b001, 32'hF0F01234, 32'h0FF0FF00, lat, bcnt);
        chk("or_res", 64'(result), 64'hFFF0FF34);
        release_out("or");
        do_op(3'b111, 32'h12345678, 32'h9, lat, bcnt);
        chk("rsvd_res_zero", {result, zero}, 64'h0_0000_0001);
        release_out("rsvd");

        do_op(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_busy_cycles", 64'(bcnt), 64'd32);
        chk("mul_prod", {result_hi, result}, 64'hFFFFFFFE_00000001);
        chk("mul_busy_done", 64'(busy), 64'd0);
        release_out("mul1");
        do_op(3'b101, 32'h12345678, 32'h00001000, lat, bcnt);
        chk("mul_prod2", {result_hi, result}, 64'h00000123_45678000);
        release_out("mul2");

        do_op(3'b110, 32'd100, 32'd7, lat, bcnt);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_qr", {result_hi, result}, {32'd2, 32'd14});
        release_out("div1");
        do_op(3'b110, 32'd9, 32'd0, lat, bcnt);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_qr", {result_hi, result}, {32'd9, 32'hFFFFFFFF});
        release_out("div0");
        do_op(3'b110, 32'hFFFFFFFF, 32'd1, lat, bcnt);
        chk("div_max", {result_hi, result}, {32'd0, 32'hFFFFFFFF});
        release_out("div2");
        do_op(3'b110, 32'd5, 32'd9, lat, bcnt);
        chk("div_small", {result_hi, result}, {32'd5, 32'd0});
        chk("div_small_zero", 64'(zero), 64'd1);
        release_out("div3");

        // Backpressure: hold result while a new request waits with in_valid high.
        do_op(3'b010, 32'd3, 32'd4, lat, bcnt);
        @(negedge clk);
        op = 3'b011; dataA = 32'd10; dataB = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd7);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_result_kept", 64'(result), 64'd7);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_result", 64'(result), 64'd7 - 64'd0 == 64'd7 ? 64'(32'd7) : 64'd0);
        release_out("bp");

        // Reset in the middle of a MULTU.
        @(negedge clk);
        op = 3'b101; dataA = 32'h1234; dataB = 32'h5678; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_busy",      64'(busy),      64'd0);
        chk("mrst_result",    {result_hi, result}, 64'd0);
        chk("mrst_zero",      64'(zero),      64'd1);
        @(negedge clk); rst_n = 1'b1;
        do_op(3'b010, 32'd1, 32'd2, lat, bcnt);
        chk("post_rst_add", 64'(result), 64'd3);
        release_out("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
